dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the MEM stage of the pipeline. It holds a
//   2^AW x 32-bit word memory with big-endian byte-lane writes.
//   - Stores complete in a single cycle and never stall the pipeline.
//   - Loads take RD_LAT cycles. A small FSM (IDLE -> WAIT -> DATA) holds
//     stallreq_o high until the registered load data is ready.
//   - Out-of-range accesses do not touch memory. They flag err_o instead.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (memory contents survive it)
//   ce_i        request valid (chip enable)
//   we_i        1 = store, 0 = load
//   addr_i      byte address; word index is addr_i[AW+1:2]
//   sel_i       byte-lane select, sel_i[3] -> data[31:24]
//   data_i      store data, already lane-replicated
//   data_o      registered load data, holds until the next load completes
//   stallreq_o  stall request while a load is outstanding
//   err_o       pulse on an out-of-range access
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int AW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
  } state_t;

  // Wait-counter preload: RD_LAT-2 extra WAIT cycles. RD_LAT=1 skips WAIT.
  localparam logic [1:0] CNT_INIT = 2'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

  logic [31:0]   mem [0:(2**AW)-1];

  state_t        state;
  logic [1:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          oor_q;
  logic          err_q;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          load_req;
  logic          store_req;
  logic          unused_addr_lsbs;

  assign idx       = addr_i[AW+1:2];
  assign in_range  = (addr_i[31:AW+2] == '0);
  assign load_req  = ce_i & ~we_i;
  assign store_req = ce_i & we_i;

  // Lane selection comes from sel_i, so the byte offset bits carry no meaning.
  assign unused_addr_lsbs = ^addr_i[1:0];

  // A load request stalls the pipeline until its data cycle.
  assign stallreq_o = ~rst & load_req & (state != ST_DATA);

  // A store error is flagged in the store cycle itself.
  // A load error is flagged in the load's DATA cycle.
  assign err_o = err_q | (~rst & store_req & ~in_range);

  // NOTE: the memory array has no reset branch. Clearing thousands of words
  // is neither wanted (contents must survive rst) nor mappable to block RAM.
  always_ff @(posedge clk) begin
    if (!rst && store_req && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_i[k]) begin
          mem[idx][8*k +: 8] <= data_i[8*k +: 8];
        end
      end
    end
  end

  // NOTE: every sequential assignment uses <= so that all registers sample
  // their pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      oor_q  <= 1'b0;
      err_q  <= 1'b0;
      data_o <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_req) begin
            idx_q <= idx;
            oor_q <= ~in_range;
            if (RD_LAT == 1) begin
              // No WAIT cycle: read the live index at the entry edge.
              state  <= ST_DATA;
              data_o <= in_range ? mem[idx] : '0;
              err_q  <= ~in_range;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end

        ST_WAIT: begin
          if (!load_req) begin
            // The pipeline flushed or redirected the load. Abandon it and
            // leave data_o untouched.
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state  <= ST_DATA;
            data_o <= oor_q ? '0 : mem[idx_q];
            err_q  <= oor_q;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        ST_DATA: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
